// File: rtl/adder_4bit.sv
// adder_4bit: registered 4-bit ripple-carry adder with carry-out, signed
// overflow, zero flag and a result-valid strobe.
// Optional macro ADDER_4BIT_INREG_EN adds an operand register stage in
// front of the adder (latency 2 instead of 1); results are otherwise identical.
module adder_4bit (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       in_valid,
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       cin,
  output logic [3:0] s,
  output logic       cout,
  output logic       ovf,
  output logic       zero,
  output logic       out_valid
);

  // Operands as seen by the adder (ports, or the optional input stage).
  logic [3:0] op_a;
  logic [3:0] op_b;
  logic       op_cin;
  logic       op_valid;

`ifdef ADDER_4BIT_INREG_EN
  logic [3:0] a_stg_q, a_stg_d;
  logic [3:0] b_stg_q, b_stg_d;
  logic       cin_stg_q, cin_stg_d;
  logic       vld_stg_q, vld_stg_d;

  // Input stage captures the ports every cycle; the valid bit travels along.
  always_comb begin
    a_stg_d   = a;
    b_stg_d   = b;
    cin_stg_d = cin;
    vld_stg_d = in_valid;
  end

  // Input stage register; reset discards any operand in flight.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      a_stg_q   <= 4'h0;
      b_stg_q   <= 4'h0;
      cin_stg_q <= 1'b0;
      vld_stg_q <= 1'b0;
    end else begin
      a_stg_q   <= a_stg_d;
      b_stg_q   <= b_stg_d;
      cin_stg_q <= cin_stg_d;
      vld_stg_q <= vld_stg_d;
    end
  end

  assign op_a     = a_stg_q;
  assign op_b     = b_stg_q;
  assign op_cin   = cin_stg_q;
  assign op_valid = vld_stg_q;
`else
  assign op_a     = a;
  assign op_b     = b;
  assign op_cin   = cin;
  assign op_valid = in_valid;
`endif

  // Ripple chain: carry[i] is the carry into cell i, carry[4] is the carry-out.
  logic [4:0] carry;
  logic [3:0] sum;

  // Four full-adder cells chained from cin.
  always_comb begin
    carry    = 5'b0;
    sum      = 4'h0;
    carry[0] = op_cin;
    for (int i = 0; i < 4; i++) begin
      sum[i]     = op_a[i] ^ op_b[i] ^ carry[i];
      carry[i+1] = (op_a[i] & op_b[i]) | (carry[i] & (op_a[i] ^ op_b[i]));
    end
  end

  logic [3:0] s_q, s_d;
  logic       cout_q, cout_d;
  logic       ovf_q, ovf_d;
  logic       zero_q, zero_d;
  logic       out_valid_q, out_valid_d;

  // Load a new result and flags on a qualified operand, otherwise hold them.
  always_comb begin
    s_d         = s_q;
    cout_d      = cout_q;
    ovf_d       = ovf_q;
    zero_d      = zero_q;
    out_valid_d = op_valid;
    if (op_valid) begin
      s_d    = sum;
      cout_d = carry[4];
      // Signed overflow: carry into the sign bit differs from carry out of it.
      ovf_d  = carry[3] ^ carry[4];
      // Zero looks at the 4-bit sum only; the carry-out is ignored.
      zero_d = (sum == 4'h0);
    end
  end

  // Output registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s_q         <= 4'h0;
      cout_q      <= 1'b0;
      ovf_q       <= 1'b0;
      zero_q      <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      s_q         <= s_d;
      cout_q      <= cout_d;
      ovf_q       <= ovf_d;
      zero_q      <= zero_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign s         = s_q;
  assign cout      = cout_q;
  assign ovf       = ovf_q;
  assign zero      = zero_q;
  assign out_valid = out_valid_q;

endmodule

// File: tb/tb_adder_4bit.sv
// tb_adder_4bit: randomized and directed stimulus against an arithmetic
// reference model, compared every cycle, plus literal spot checks.
module tb_adder_4bit;

`ifdef ADDER_4BIT_INREG_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 1;
`endif

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       in_valid = 1'b0;
  logic [3:0] a = 4'h0;
  logic [3:0] b = 4'h0;
  logic       cin = 1'b0;
  logic [3:0] s;
  logic       cout;
  logic       ovf;
  logic       zero;
  logic       out_valid;

  adder_4bit dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .a         (a),
    .b         (b),
    .cin       (cin),
    .s         (s),
    .cout      (cout),
    .ovf       (ovf),
    .zero      (zero),
    .out_valid (out_valid)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int errors  = 0;

  // Reference model state.
  logic [3:0] m_s = 4'h0;
  logic       m_cout = 1'b0;
  logic       m_ovf = 1'b0;
  logic       m_zero = 1'b0;
  logic       m_valid = 1'b0;
  logic       m_live = 1'b0;
  // One-deep delay line used only when latency is 2.
  logic       p_v = 1'b0;
  logic [3:0] p_a = 4'h0;
  logic [3:0] p_b = 4'h0;
  logic       p_cin = 1'b0;

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Plain arithmetic: unsigned total for sum/carry, signed range for overflow.
  task automatic ref_add(input logic [3:0] x, input logic [3:0] y, input logic ci,
                         output logic [3:0] rs, output logic rc, output logic ro,
                         output logic rz);
    int tot;
    int sx;
    int sy;
    int st;
    tot = int'(x) + int'(y) + int'(ci);
    sx  = x[3] ? int'(x) - 16 : int'(x);
    sy  = y[3] ? int'(y) - 16 : int'(y);
    st  = sx + sy + int'(ci);
    rs  = 4'(tot % 16);
    rc  = (tot >= 16);
    ro  = (st > 7) || (st < -8);
    rz  = ((tot % 16) == 0);
  endtask

  // Model update on every rising edge.
  always @(posedge clk) begin
    logic       fv;
    logic [3:0] fa;
    logic [3:0] fb;
    logic       fc;
    logic [3:0] ns;
    logic       nc;
    logic       no;
    logic       nz;
    m_live <= 1'b1;
    if (!rst_n) begin
      m_s <= 4'h0; m_cout <= 1'b0; m_ovf <= 1'b0; m_zero <= 1'b0; m_valid <= 1'b0;
      p_v <= 1'b0; p_a <= 4'h0; p_b <= 4'h0; p_cin <= 1'b0;
    end else begin
      if (in_valid) vectors <= vectors + 1;
      if (LAT == 1) begin
        fv = in_valid; fa = a; fb = b; fc = cin;
      end else begin
        fv = p_v; fa = p_a; fb = p_b; fc = p_cin;
      end
      p_v <= in_valid; p_a <= a; p_b <= b; p_cin <= cin;
      if (fv) begin
        ref_add(fa, fb, fc, ns, nc, no, nz);
        m_s <= ns; m_cout <= nc; m_ovf <= no; m_zero <= nz;
      end
      m_valid <= fv;
    end
  end

  // Every-cycle comparison on the falling edge.
  always @(negedge clk) begin
    if (m_live) begin
      chk("out_valid", {7'b0, out_valid}, {7'b0, m_valid});
      chk("s",         {4'b0, s},         {4'b0, m_s});
      chk("cout",      {7'b0, cout},      {7'b0, m_cout});
      chk("ovf",       {7'b0, ovf},       {7'b0, m_ovf});
      chk("zero",      {7'b0, zero},      {7'b0, m_zero});
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One qualified add followed by idle, then literal checks of DUT and model.
  task automatic lit(input string nm, input logic [3:0] x, input logic [3:0] y,
                     input logic ci, input logic [3:0] es, input logic ec,
                     input logic eo, input logic ez);
    a = x; b = y; cin = ci; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    repeat (LAT - 1) tick();
    chk({nm, "_s"},     {4'b0, s},    {4'b0, es});
    chk({nm, "_cout"},  {7'b0, cout}, {7'b0, ec});
    chk({nm, "_ovf"},   {7'b0, ovf},  {7'b0, eo});
    chk({nm, "_zero"},  {7'b0, zero}, {7'b0, ez});
    chk({nm, "_valid"}, {7'b0, out_valid}, 8'h01);
    chk({nm, "_model"}, {1'b0, m_zero, m_ovf, m_cout, m_s}, {1'b0, ez, eo, ec, es});
  endtask

  initial begin
    logic [8:0] v;

    // Reset held two cycles while operands are offered.
    rst_n = 1'b0; in_valid = 1'b1; a = 4'hF; b = 4'h1; cin = 1'b0;
    repeat (2) tick();
    chk("rst_s", {4'b0, s}, 8'h00);
    chk("rst_flags", {5'b0, cout, ovf, zero}, 8'h00);
    chk("rst_valid", {7'b0, out_valid}, 8'h00);
    rst_n = 1'b1; in_valid = 1'b0;
    tick();

    // Small sweep over (a,b,cin) in {0,1}.
    for (int i = 0; i < 8; i++) begin
      v = 9'(i);
      a = {3'b0, v[2]}; b = {3'b0, v[1]}; cin = v[0]; in_valid = 1'b1;
      tick();
    end
    in_valid = 1'b0;
    repeat (LAT + 1) tick();

    // Carry/wrap and signed overflow corners.
    lit("wrap_f01", 4'hF, 4'h0, 1'b1, 4'h0, 1'b1, 1'b0, 1'b1);
    lit("wrap_ff1", 4'hF, 4'hF, 1'b1, 4'hF, 1'b1, 1'b0, 1'b0);
    lit("ovf_71",   4'h7, 4'h1, 1'b0, 4'h8, 1'b0, 1'b1, 1'b0);
    lit("ovf_88",   4'h8, 4'h8, 1'b0, 4'h0, 1'b1, 1'b1, 1'b1);

    // Hold: 3+4 then idle cycles with random operands.
    lit("hold_34", 4'h3, 4'h4, 1'b0, 4'h7, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      a = 4'($urandom); b = 4'($urandom); cin = 1'($urandom);
      tick();
      chk("hold_s", {4'b0, s}, 8'h07);
      chk("hold_valid", {7'b0, out_valid}, 8'h00);
    end

    // Exhaustive back-to-back stream.
    for (int i = 0; i < 512; i++) begin
      v = 9'(i);
      a = v[8:5]; b = v[4:1]; cin = v[0]; in_valid = 1'b1;
      tick();
    end
    in_valid = 1'b0;
    repeat (LAT + 1) tick();

    // Random traffic with a mid-stream reset.
    for (int i = 0; i < 400; i++) begin
      a = 4'($urandom); b = 4'($urandom); cin = 1'($urandom);
      in_valid = ($urandom_range(0, 3) != 0);
      rst_n = !(i == 200 || i == 201);
      tick();
    end
    rst_n = 1'b1; in_valid = 1'b0;
    repeat (LAT + 2) tick();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
